// File: rtl/aes_dec_rk.sv
// AES inverse cipher, one round per clock. Round keys come combinationally
// from an external expanded-key store addressed by rk_idx_o.
package aes_dec_rk_pkg;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction
endpackage

module aes_inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  import aes_dec_rk_pkg::*;
  localparam logic [7:0] INV_AFF_C = 8'h05;
  logic [7:0] aff;
  logic [7:0] pw;

  always_comb begin
    aff = 8'h00;
    for (int i = 0; i < 8; i++) begin
      aff[i] = in_i[(i + 2) % 8] ^ in_i[(i + 5) % 8] ^ in_i[(i + 7) % 8] ^ INV_AFF_C[i];
    end
    // Field inverse computed as aff^254, which maps 0 to 0 as AES requires.
    pw = aff;
    for (int i = 0; i < 6; i++) begin
      pw = gf_mul(gf_mul(pw, pw), aff);
    end
    out_o = gf_mul(pw, pw);
  end
endmodule

module aes_inv_mixcol (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  import aes_dec_rk_pkg::*;
  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_i;
  assign col_o = {
    gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
    gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
    gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
    gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
  };
endmodule

module aes_dec_rk #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         data_v_i,
  output logic         data_ready_o,
  input  logic [127:0] data_i,
  input  logic         flush_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         res_v_o,
  input  logic         res_ready_i,
  output logic [127:0] res_o,
  output logic         busy_o
);
  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_dec_rk: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX  = 4'(NR);
  localparam logic [3:0] NR_LAST = 4'(NR - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;
  logic [127:0] sb_out, ark, mc_out, round_out;

  // InvShiftRows is pure wiring: output byte gi reads the byte one row-shift to its left.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    localparam int ROW = gi % 4;
    localparam int SRC = ROW + 4 * (((gi / 4) - ROW + 4) % 4);
    aes_inv_sbox u_sbox (
      .in_i  (data_q[127 - 8 * SRC -: 8]),
      .out_o (sb_out[127 - 8 * gi -: 8])
    );
  end

  assign ark = sb_out ^ rk_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    aes_inv_mixcol u_mix (
      .col_i (ark[127 - 32 * gi -: 32]),
      .col_o (mc_out[127 - 32 * gi -: 32])
    );
  end

  assign round_out = (rnd_q == 4'd0) ? ark : mc_out;
  assign res_o     = data_q;

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    data_d       = data_q;
    data_ready_o = 1'b0;
    rk_idx_o     = NR_IDX;
    res_v_o      = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      IDLE: data_ready_o = 1'b1;
      ROUND: begin
        busy_o   = 1'b1;
        rk_idx_o = rnd_q;
        data_d   = round_out;
        if (rnd_q == 4'd0) state_d = DONE;
        else               rnd_d   = rnd_q - 4'd1;
      end
      DONE: begin
        res_v_o      = 1'b1;
        data_ready_o = res_ready_i;
        if (res_ready_i && !data_v_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Accept from IDLE or as a same-cycle retire+accept from DONE.
    if (data_v_i && data_ready_o) begin
      data_d  = data_i ^ rk_i;
      rnd_d   = NR_LAST;
      state_d = ROUND;
    end
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      data_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_aes_dec_rk.sv
// Bench for aes_dec_rk at NR=10/12/14: FIPS-197 vectors plus random blocks made
// by a forward-cipher reference model, and flush/backpressure/reset sequences.
module tb_aes_dec_rk;
  logic         clk;
  logic         nreset;
  logic         data_v    [3];
  logic         data_ready[3];
  logic [127:0] data_in   [3];
  logic         flush     [3];
  logic [3:0]   rk_idx    [3];
  logic [127:0] rk        [3];
  logic         res_v     [3];
  logic         res_ready [3];
  logic [127:0] res       [3];
  logic         busy      [3];

  logic [127:0] rks  [3][16];
  logic [7:0]   sbox [256];

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ks
    assign rk[gi] = rks[gi][rk_idx[gi]];
  end

  aes_dec_rk #(.NR(10)) u_dut10 (.clk(clk), .nreset(nreset), .data_v_i(data_v[0]),
    .data_ready_o(data_ready[0]), .data_i(data_in[0]), .flush_i(flush[0]), .rk_idx_o(rk_idx[0]),
    .rk_i(rk[0]), .res_v_o(res_v[0]), .res_ready_i(res_ready[0]), .res_o(res[0]), .busy_o(busy[0]));
  aes_dec_rk #(.NR(12)) u_dut12 (.clk(clk), .nreset(nreset), .data_v_i(data_v[1]),
    .data_ready_o(data_ready[1]), .data_i(data_in[1]), .flush_i(flush[1]), .rk_idx_o(rk_idx[1]),
    .rk_i(rk[1]), .res_v_o(res_v[1]), .res_ready_i(res_ready[1]), .res_o(res[1]), .busy_o(busy[1]));
  aes_dec_rk #(.NR(14)) u_dut14 (.clk(clk), .nreset(nreset), .data_v_i(data_v[2]),
    .data_ready_o(data_ready[2]), .data_i(data_in[2]), .flush_i(flush[2]), .rk_idx_o(rk_idx[2]),
    .rk_i(rk[2]), .res_v_o(res_v[2]), .res_ready_i(res_ready[2]), .res_o(res[2]), .busy_o(busy[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic void expand(input int k, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr, nk;
    nr = 10 + 2 * k;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255 - 32 * i -: 32];
      else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i - nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rks[k][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
      else         rks[k][r] = 128'd0;
    end
  endfunction

  function automatic logic [127:0] encrypt(input int k, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    int nr;
    nr = 10 + 2 * k;
    v  = pt ^ rks[k][0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[v[127 - 8 * i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[j + 4 * c] = s[j + 4 * ((c + j) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else s = t;
      for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = s[i];
      v = v ^ rks[k][r];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one block, then watch latency, round-key index sequence and result.
  task automatic run_block(input int k, input logic [127:0] ct, input logic [127:0] pt,
                           input bit noise, input string tag);
    int n, nr;
    bit ctl_ok;
    nr = 10 + 2 * k;
    ctl_ok = 1'b1;
    data_in[k] = ct;
    data_v[k]  = 1'b1;
    n = 0;
    while (!data_ready[k] && n < 100) begin step(); n++; end
    chk({tag, " ready"}, 128'(data_ready[k]), 128'(1));
    step();
    if (noise) data_in[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
    else       data_v[k]  = 1'b0;
    n = 1;
    while (!res_v[k] && n < nr + 20) begin
      if (busy[k] !== 1'b1 || data_ready[k] !== 1'b0 || rk_idx[k] !== 4'(nr - n)) ctl_ok = 1'b0;
      step();
      n++;
      if (noise) data_in[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    data_v[k] = 1'b0;
    chk({tag, " latency"}, 128'(n), 128'(nr + 1));
    chk({tag, " round ctl"}, 128'(ctl_ok), 128'(1));
    chk({tag, " plaintext"}, res[k], pt);
    $display("blk %-12s nr=%0d ct=%h res=%h lat=%0d", tag, nr, ct, res[k], n);
  endtask

  typedef struct {
    int           k;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         tbl [15];
    logic [255:0] key128;
    logic [127:0] pt_a, pt_b, ct_a, ct_b, hold;
    bit           stable, seen;
    int           n;

    for (int k = 0; k < 3; k++) begin
      data_v[k] = 1'b0; data_in[k] = 128'd0; flush[k] = 1'b0; res_ready[k] = 1'b1;
    end
    nreset = 1'b0;
    build_sbox();

    tbl[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    tbl[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
               128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff};
    tbl[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
    for (int i = 3; i < 15; i++) begin
      tbl[i].k   = i % 3;
      tbl[i].key = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
      if (tbl[i].k == 0) tbl[i].key[127:0] = 128'h0;
      if (tbl[i].k == 1) tbl[i].key[63:0]  = 64'h0;
      tbl[i].pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(tbl[i].k, tbl[i].key);
      tbl[i].ct = encrypt(tbl[i].k, tbl[i].pt);
    end

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset res_o", res[k], 128'd0);
      chk("reset res_v", 128'(res_v[k]), 128'(0));
      chk("reset busy", 128'(busy[k]), 128'(0));
      chk("reset ready", 128'(data_ready[k]), 128'(1));
      chk("reset rk_idx", 128'(rk_idx[k]), 128'(10 + 2 * k));
    end
    nreset = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      expand(tbl[i].k, tbl[i].key);
      run_block(tbl[i].k, tbl[i].ct, tbl[i].pt, bit'(i % 2), $sformatf("vec%0d", i));
    end
    step();

    key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    expand(0, key128);
    pt_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    pt_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    ct_a = encrypt(0, pt_a);
    ct_b = encrypt(0, pt_b);

    // Backpressure: result held 20 cycles while a new block waits.
    res_ready[0] = 1'b0;
    run_block(0, ct_a, pt_a, 1'b0, "bp first");
    hold = res[0];
    stable = 1'b1;
    data_in[0] = ct_b;
    data_v[0]  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (res_v[0] !== 1'b1 || res[0] !== hold || data_ready[0] !== 1'b0) stable = 1'b0;
      step();
    end
    chk("bp hold stable", 128'(stable), 128'(1));
    res_ready[0] = 1'b1;
    run_block(0, ct_b, pt_b, 1'b0, "bp next");

    // Flush at round 5.
    data_in[0] = ct_a;
    data_v[0]  = 1'b1;
    n = 0;
    while (!data_ready[0] && n < 100) begin step(); n++; end
    step();
    data_v[0] = 1'b0;
    n = 0;
    while (!(busy[0] && rk_idx[0] == 4'd5) && n < 30) begin step(); n++; end
    chk("flush reach rnd5", 128'(rk_idx[0]), 128'(5));
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    chk("flush idle", 128'({busy[0], data_ready[0], res_v[0]}), 128'(3'b010));
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (res_v[0]) seen = 1'b1;
      step();
    end
    chk("flush no result", 128'(seen), 128'(0));
    run_block(0, ct_b, pt_b, 1'b0, "post flush");

    // Flush wins over a same-cycle retire+accept in DONE.
    flush[0]   = 1'b1;
    data_in[0] = ct_a;
    data_v[0]  = 1'b1;
    step();
    flush[0] = 1'b0;
    data_v[0] = 1'b0;
    chk("flush over accept", 128'({busy[0], res_v[0], data_ready[0]}), 128'(3'b001));
    step();

    // Asynchronous reset pulse between edges, mid-ROUND.
    data_in[0] = ct_a;
    data_v[0]  = 1'b1;
    step();
    data_v[0] = 1'b0;
    repeat (3) step();
    chk("arst pre busy", 128'(busy[0]), 128'(1));
    #2;
    nreset = 1'b0;
    #1;
    chk("arst res_o", res[0], 128'd0);
    chk("arst ctl", 128'({res_v[0], busy[0], data_ready[0]}), 128'(3'b001));
    chk("arst rk_idx", 128'(rk_idx[0]), 128'(10));
    #2;
    nreset = 1'b1;
    step();
    run_block(0, ct_a, pt_a, 1'b0, "post reset");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_dec_rk.md
AES_DEC_RK -- requirements
Module: aes_dec_rk

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of AES rounds; legal values are 10, 12 and 14, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port nreset, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port data_v_i, input, 1, meaning the ciphertext on data_i is valid.
REQ-005 The block SHALL have port data_ready_o, output, 1, meaning the block can accept a ciphertext this cycle.
REQ-006 The block SHALL have port data_i, input, 128, the ciphertext; byte 0 of the state is data_i[127:120].
REQ-007 The block SHALL have port flush_i, input, 1, a synchronous abort.
REQ-008 The block SHALL have port rk_idx_o, output, 4, the index of the round key requested this cycle.
REQ-009 The block SHALL have port rk_i, input, 128, the round key for rk_idx_o; it is returned combinationally in the same cycle by the external expanded-key store.
REQ-010 The block SHALL have port res_v_o, output, 1, meaning the plaintext on res_o is valid.
REQ-011 The block SHALL have port res_ready_i, input, 1, meaning the consumer accepts the plaintext.
REQ-012 The block SHALL have port res_o, output, 128, the plaintext, with the same byte order as data_i.
REQ-013 The block SHALL have port busy_o, output, 1, asserted while in state ROUND.

Function
REQ-014 The block SHALL implement the states IDLE, ROUND and DONE, a 4-bit round counter rnd_q, and a 128-bit state register data_q that drives res_o directly.
REQ-015 In IDLE, data_ready_o SHALL be 1, rk_idx_o SHALL be NR, and res_v_o SHALL be 0.
REQ-016 On accept (data_v_i and data_ready_o both high), data_q SHALL load data_i XOR rk_i, rnd_q SHALL load NR-1, and the state SHALL become ROUND.
REQ-017 In ROUND, rk_idx_o SHALL equal rnd_q.
REQ-018 In ROUND with rnd_q greater than 0, data_q SHALL load InvMixColumns(InvSubBytes(InvShiftRows(data_q)) XOR rk_i), and rnd_q SHALL decrement.
REQ-019 In ROUND with rnd_q equal to 0, data_q SHALL load InvSubBytes(InvShiftRows(data_q)) XOR rk_i, with InvMixColumns bypassed, and the state SHALL become DONE.
REQ-020 In DONE, res_v_o SHALL be 1; res_o and res_v_o SHALL hold stable until res_ready_i is high.
REQ-021 In DONE, data_ready_o SHALL equal res_ready_i and rk_idx_o SHALL be NR.
- With res_ready_i high and data_v_i high, the result SHALL retire and the new ciphertext SHALL be accepted in the same cycle (back-to-back).
- With res_ready_i high and data_v_i low, the state SHALL become IDLE.
REQ-022 Latency SHALL be NR+1 clock edges from the accept edge to the first cycle with res_v_o high, giving a throughput of one block per NR+1 cycles under back-to-back operation.
REQ-023 data_v_i SHALL be ignored in ROUND (data_ready_o is 0 there); the in-flight block SHALL be unaffected.
REQ-024 flush_i high SHALL force IDLE on the next edge from any state and discard any in-flight or pending result.
- res_v_o SHALL be 0 in the following cycle.
- flush_i SHALL take priority over accept and over retire in the same cycle.
REQ-025 rk_i SHALL be sampled only in the cycle in which rk_idx_o presents its index; the block SHALL not register round keys.
REQ-026 The InvSubBytes and InvMixColumns datapaths SHALL reuse the team's existing inverse S-box and inverse column-mix cells: 16 S-box instances and 4 column-mix instances.

Reset
REQ-027 While nreset is low, the state SHALL be IDLE, rnd_q SHALL be 0 and data_q SHALL be 0, so res_o=0, res_v_o=0, busy_o=0, data_ready_o=1 and rk_idx_o=NR.
REQ-028 Reset asserted mid-operation SHALL discard the block immediately; the first accept after release SHALL decrypt correctly.

Verification
REQ-029 NR=10: the bench SHALL apply ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with round keys expanded from key 000102030405060708090a0b0c0d0e0f.
- The required response is res_o=00112233445566778899aabbccddeeff with res_v_o rising 11 edges after accept.
REQ-030 NR=12 and NR=14: the bench SHALL apply the FIPS-197 C.2 and C.3 ciphertexts dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089.
- The required response is 00112233445566778899aabbccddeeff at 13 and 15 edges after accept, respectively.
REQ-031 Backpressure: the bench SHALL hold res_ready_i low for 20 cycles after a result appears.
- The required response is res_o and res_v_o stable throughout, with data_ready_o low.
- After res_ready_i rises with data_v_i high, the next block SHALL complete NR+1 edges later.
REQ-032 Flush: the bench SHALL assert flush_i at round 5.
- The required response is IDLE on the next edge with res_v_o never rising.
- A following accept SHALL produce the correct plaintext.
REQ-033 Async reset: the bench SHALL pulse nreset low between clock edges mid-ROUND.
- The required response is that outputs take their reset values without waiting for a clock edge.
- A new block after release SHALL decrypt correctly.
